// File: rtl/alu_issue_if.sv
// Request/response and ALU-side signal bundle for alu_issue_ctrl.
// The slave modport is the issue controller; the master modport is the requester plus the ALU.
interface alu_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [5:0]  alu_signal;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [31:0] alu_output;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_md;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_output, rsp_ready,
        output req_ready, alu_signal, alu_dataA, alu_dataB,
               rsp_valid, rsp_hi, rsp_lo, rsp_md, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_output, rsp_ready,
        input  req_ready, alu_signal, alu_dataA, alu_dataB,
               rsp_valid, rsp_hi, rsp_lo, rsp_md, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to an external multi-cycle ALU and returns HI/LO results.
// The same reset input is wired to the downstream ALU, so both sides clear together.
//
// state  | meaning
// IDLE   | ready for a request, ALU inputs parked at 0
// EXEC   | single-cycle op on the ALU, result captured at cycle end
// MD_RUN | DIVU/MULTU held on the ALU for MD_WAIT cycles
// RD_HI  | MFHI issued, HI captured at cycle end
// RD_LO  | MFLO issued, LO captured at cycle end
// RESP   | response presented until rsp_ready
module alu_issue_ctrl #(
    parameter int MD_WAIT = 35
) (
    input  logic       clk,
    input  logic       reset,
    alu_issue_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXEC, MD_RUN, RD_HI, RD_LO, RESP} state_t;

    localparam logic [5:0] OP_MFHI = 6'd16;
    localparam logic [5:0] OP_MFLO = 6'd18;

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [5:0]  op_q;
    logic [31:0] a_q, b_q, hi_q, lo_q;
    logic        md_q, err_q;
    logic        ready, accept, is_single, is_md;

    always_comb begin
        is_single = 1'b0;
        is_md     = 1'b0;
        case (bus.req_op)
            6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2: is_single = 1'b1;
            6'd27, 6'd25:                            is_md     = 1'b1;
            default: ;
        endcase
    end

    assign accept = ready && bus.req_valid;

    always_comb begin
        state_nx       = state;
        ready          = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.alu_signal = 6'd0;
        bus.alu_dataA  = 32'd0;
        bus.alu_dataB  = 32'd0;
        case (state)
            IDLE: begin
                ready = !reset;
                if (ready && bus.req_valid) begin
                    if (is_single)  state_nx = EXEC;
                    else if (is_md) state_nx = MD_RUN;
                    else            state_nx = RESP;
                end
            end
            EXEC: begin
                bus.alu_signal = op_q;
                bus.alu_dataA  = a_q;
                bus.alu_dataB  = b_q;
                state_nx       = RESP;
            end
            MD_RUN: begin
                bus.alu_signal = op_q;
                bus.alu_dataA  = a_q;
                bus.alu_dataB  = b_q;
                if (cnt == 8'd0) state_nx = RD_HI;
            end
            RD_HI: begin
                bus.alu_signal = OP_MFHI;
                state_nx       = RD_LO;
            end
            RD_LO: begin
                bus.alu_signal = OP_MFLO;
                state_nx       = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            op_q  <= 6'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            md_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= bus.req_op;
                        a_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        hi_q  <= 32'd0;
                        lo_q  <= 32'd0;
                        md_q  <= 1'b0;
                        err_q <= !(is_single || is_md);
                        // terminal count at 0 gives exactly MD_WAIT cycles in MD_RUN
                        if (is_md) cnt <= 8'(MD_WAIT - 1);
                    end
                end
                EXEC:   lo_q <= bus.alu_output;
                MD_RUN: if (cnt != 8'd0) cnt <= cnt - 8'd1;
                RD_HI:  hi_q <= bus.alu_output;
                RD_LO: begin
                    lo_q <= bus.alu_output;
                    md_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_hi    = hi_q;
    assign bus.rsp_lo    = lo_q;
    assign bus.rsp_md    = md_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter MD_WAIT, default 35: cycles a DIVU/MULTU opcode is held on alu_signal before the HI read.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; also drives the downstream ALU reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_op  input  6  ALU opcode: 36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT, 2 SRL, 27 DIVU, 25 MULTU.
REQ-007 req_a, req_b  input  32  operands, unsigned.
REQ-008 alu_signal  output  6  opcode driven to the ALU.
REQ-009 alu_dataA, alu_dataB  output  32  operands driven to the ALU.
REQ-010 alu_output  input  32  ALU result.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_hi, rsp_lo  output  32  results: HI/LO for DIVU/MULTU; rsp_hi=0 and rsp_lo=result for single-cycle ops.
REQ-014 rsp_md  output  1  response came from DIVU/MULTU.
REQ-015 rsp_err  output  1  opcode unsupported.

Function
REQ-016 States: IDLE, EXEC, MD_RUN, RD_HI, RD_LO, RESP.
REQ-017 req_ready=1 only in IDLE; a request is accepted on the edge where req_valid && req_ready.
REQ-018 Supported single op accepted -> EXEC; alu_signal=req_op and operands driven for exactly one cycle; alu_output captured into rsp_lo at the edge ending EXEC; -> RESP.
REQ-019 DIVU/MULTU accepted -> MD_RUN; alu_signal, alu_dataA and alu_dataB held stable for exactly MD_WAIT cycles (8-bit down-counter); -> RD_HI.
REQ-020 RD_HI: alu_signal=16 (MFHI) for one cycle; alu_output captured into rsp_hi at cycle end; -> RD_LO.
REQ-021 RD_LO: alu_signal=18 (MFLO) for one cycle; alu_output captured into rsp_lo at cycle end; -> RESP with rsp_md=1.
REQ-022 Unsupported opcode accepted -> RESP directly, rsp_err=1, rsp_hi=rsp_lo=0; no ALU activity.
REQ-023 In IDLE and RESP: alu_signal=0, alu_dataA=0, alu_dataB=0.
REQ-024 rsp_valid=1 only in RESP; rsp_hi, rsp_lo, rsp_md and rsp_err stay stable while rsp_valid && !rsp_ready.
REQ-025 RESP -> IDLE on the edge where rsp_ready=1; a new request cannot be accepted in that same cycle.
REQ-026 Latency, counted in edges from acceptance to the first cycle with rsp_valid=1: single op 2; error 1; DIVU/MULTU MD_WAIT+3 (38 at default).
REQ-027 req_valid and req_op changes while not in IDLE are ignored; operands are registered at acceptance.
REQ-028 MD_WAIT=0 is illegal; behaviour is required only for 1..255.

Reset
REQ-029 reset asserted: immediately (no clock edge needed) state=IDLE, counter=0, all outputs 0 (req_ready=0 while reset high), any in-flight operation or pending response discarded.
REQ-030 First cycle after reset deassertion: req_ready=1.
REQ-031 Reset during MD_RUN/RD_HI/RD_LO: no response is ever produced for that request.

Verification
REQ-032 ADD(32) a=7 b=5, rsp_ready=1 -> rsp_valid 2 edges after acceptance, rsp_lo=12, rsp_hi=0, rsp_md=0, rsp_err=0.
REQ-033 SUB(34) a=3 b=5 -> rsp_lo=4294967294; then SLT(42) a=3 b=5 -> rsp_lo=1.
REQ-034 MULTU(25) a=65536 b=65536 -> alu_signal=25 for 35 cycles, then 16, then 18; rsp_hi=1, rsp_lo=0, rsp_md=1, rsp_valid at edge 38.
REQ-035 DIVU(27) a=100 b=7 with rsp_ready=0 for 5 cycles -> rsp_hi=2, rsp_lo=14 held stable, IDLE one edge after rsp_ready rises.
REQ-036 Opcode 9 a=1 b=1 -> rsp_err=1, rsp_lo=0, alu_signal stays 0, rsp_valid 1 edge after acceptance.
REQ-037 Reset asserted mid-clock 10 cycles into MULTU -> outputs 0 before the next edge, no rsp_valid; next ADD 1+1 returns 2.
